// File: rtl/vga_pkg.sv
// Shared VGA timing constants, frame buffer geometry and colour helpers
// for the frame-buffer display path.
package vga_pkg;

  localparam int CLK_DIV = 4;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int FB_W = 320;
  localparam int FB_H = 240;

  typedef enum logic [2:0] {
    BACK = 3'b000,
    BALL = 3'b100,
    PADL = 3'b010,
    PADR = 3'b001
  } color_e;

  localparam logic [11:0] RGB_WHITE = 12'hFFF;
  localparam logic [11:0] RGB_BLACK = 12'h000;

  // Expand a {R,G,B} bit triple into three 4-bit channels.
  function automatic logic [11:0] color_to_rgb(input logic [2:0] c);
    return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
  endfunction

endpackage

// File: rtl/vga_fb_display_timing.sv
// VGA raster timing: pixel-tick divider, h/v counters, raw syncs,
// visible flag and the start-of-vblank pulse. Sync and visible outputs are
// combinational from the counters; the top delays them to match its
// read pipeline.
module vga_fb_display_timing #(
  parameter int CLK_DIV = vga_pkg::CLK_DIV,
  parameter int H_VIS   = vga_pkg::H_VIS,
  parameter int H_FP    = vga_pkg::H_FP,
  parameter int H_SYNC  = vga_pkg::H_SYNC,
  parameter int H_BP    = vga_pkg::H_BP,
  parameter int V_VIS   = vga_pkg::V_VIS,
  parameter int V_FP    = vga_pkg::V_FP,
  parameter int V_SYNC  = vga_pkg::V_SYNC,
  parameter int V_BP    = vga_pkg::V_BP
) (
  input  logic       i_clk,
  input  logic       i_reset,
  output logic [9:0] o_hcount,
  output logic [9:0] o_vcount,
  output logic       o_hs,
  output logic       o_vs,
  output logic       o_visible,
  output logic       o_frame_start
);

  localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VIS + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VIS + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  logic [7:0] r_div;
  logic [9:0] r_hcount;
  logic [9:0] r_vcount;
  logic       r_frame_start;
  logic       w_tick;

  assign w_tick = (r_div == 8'(CLK_DIV - 1));

  // Divider and raster counters; frame_start is raised on the same edge the
  // counters step onto line V_VIS, column 0.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_div         <= '0;
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      if (w_tick) begin
        r_div <= '0;
        if (r_hcount == 10'(H_TOT - 1)) begin
          r_hcount <= '0;
          if (r_vcount == 10'(V_TOT - 1))
            r_vcount <= '0;
          else
            r_vcount <= r_vcount + 10'd1;
          if (r_vcount == 10'(V_VIS - 1))
            r_frame_start <= 1'b1;
        end else begin
          r_hcount <= r_hcount + 10'd1;
        end
      end else begin
        r_div <= r_div + 8'd1;
      end
    end
  end

  assign o_hcount      = r_hcount;
  assign o_vcount      = r_vcount;
  assign o_hs          = !((r_hcount >= 10'(HS_START)) && (r_hcount < 10'(HS_END)));
  assign o_vs          = !((r_vcount >= 10'(VS_START)) && (r_vcount < 10'(VS_END)));
  assign o_visible     = (r_hcount < 10'(H_VIS)) && (r_vcount < 10'(V_VIS));
  assign o_frame_start = r_frame_start;

endmodule

// File: rtl/vga_fb_display.sv
// Frame-buffer VGA display: 320x240x3 buffer written by the game's pixel
// stream, scanned out 2x-doubled as 640x480 VGA from the system clock.
// Optional macro VGA_FB_BORDER_EN forces a white one-pixel border on the
// outermost visible rows and columns.
module vga_fb_display #(
  parameter int CLK_DIV = vga_pkg::CLK_DIV,
  parameter int FB_W    = vga_pkg::FB_W,
  parameter int FB_H    = vga_pkg::FB_H,
  parameter int H_VIS   = vga_pkg::H_VIS,
  parameter int H_FP    = vga_pkg::H_FP,
  parameter int H_SYNC  = vga_pkg::H_SYNC,
  parameter int H_BP    = vga_pkg::H_BP,
  parameter int V_VIS   = vga_pkg::V_VIS,
  parameter int V_FP    = vga_pkg::V_FP,
  parameter int V_SYNC  = vga_pkg::V_SYNC,
  parameter int V_BP    = vga_pkg::V_BP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] wr_x,
  input  logic [7:0] wr_y,
  input  logic [2:0] wr_color,
  input  logic       wr_en,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       frame_start
);

  import vga_pkg::*;

  localparam int FB_DEPTH = FB_W * FB_H;

  logic [9:0]  w_hcount;
  logic [9:0]  w_vcount;
  logic        w_hs_raw;
  logic        w_vs_raw;
  logic        w_visible;
  logic        w_border;
  logic        w_wr_ok;
  logic [16:0] w_wr_y;
  logic [16:0] w_wr_addr;
  logic [16:0] w_rd_row;
  logic [16:0] w_rd_addr;

  logic [2:0]  r_mem [0:FB_DEPTH-1];
  logic [2:0]  r_rd_data;
  logic        r_hs_d1;
  logic        r_vs_d1;
  logic        r_vis_d1;
  logic        r_bdr_d1;
  logic        r_hs;
  logic        r_vs;
  logic [11:0] r_rgb;

  vga_fb_display_timing #(
    .CLK_DIV (CLK_DIV),
    .H_VIS   (H_VIS),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_VIS   (V_VIS),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP)
  ) u_timing (
    .i_clk         (clk),
    .i_reset       (reset),
    .o_hcount      (w_hcount),
    .o_vcount      (w_vcount),
    .o_hs          (w_hs_raw),
    .o_vs          (w_vs_raw),
    .o_visible     (w_visible),
    .o_frame_start (frame_start)
  );

  // Row stride is 320 (256 + 64) so the multiply reduces to two shifts.
  // Out-of-range coordinates are rejected before they can wrap into a
  // neighbouring row.
  assign w_wr_ok   = wr_en && (wr_x < 9'(FB_W)) && (wr_y < 8'(FB_H));
  assign w_wr_y    = {9'd0, wr_y};
  assign w_wr_addr = (w_wr_y << 8) + (w_wr_y << 6) + {8'd0, wr_x};

  // Blanking lines would index past the buffer, so the read address is
  // parked at 0 outside the visible area; the colour is masked anyway.
  assign w_rd_row  = {7'd0, w_vcount} >> 1;
  assign w_rd_addr = w_visible ?
                     ((w_rd_row << 8) + (w_rd_row << 6) + ({7'd0, w_hcount} >> 1)) :
                     17'd0;

`ifdef VGA_FB_BORDER_EN
  assign w_border = w_visible &&
                    ((w_hcount == 10'd0) || (w_hcount == 10'(H_VIS - 1)) ||
                     (w_vcount == 10'd0) || (w_vcount == 10'(V_VIS - 1)));
`else
  assign w_border = 1'b0;
`endif

  // Single-port-style buffer: read-first, so a same-edge write to the scanned
  // address shows up only on a later read.
  always_ff @(posedge clk) begin
    if (w_wr_ok)
      r_mem[w_wr_addr] <= wr_color;
    r_rd_data <= r_mem[w_rd_addr];
  end

  // Two-stage output pipeline; syncs and flags ride alongside the RAM read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hs_d1  <= 1'b1;
      r_vs_d1  <= 1'b1;
      r_vis_d1 <= 1'b0;
      r_bdr_d1 <= 1'b0;
      r_hs     <= 1'b1;
      r_vs     <= 1'b1;
      r_rgb    <= RGB_BLACK;
    end else begin
      r_hs_d1  <= w_hs_raw;
      r_vs_d1  <= w_vs_raw;
      r_vis_d1 <= w_visible;
      r_bdr_d1 <= w_border;
      r_hs     <= r_hs_d1;
      r_vs     <= r_vs_d1;
      if (!r_vis_d1)
        r_rgb <= RGB_BLACK;
      else if (r_bdr_d1)
        r_rgb <= RGB_WHITE;
      else
        r_rgb <= color_to_rgb(r_rd_data);
    end
  end

  assign vga_hs = r_hs;
  assign vga_vs = r_vs;
  assign vga_r  = r_rgb[11:8];
  assign vga_g  = r_rgb[7:4];
  assign vga_b  = r_rgb[3:0];

endmodule

// File: tb/tb_vga_fb_display.sv
// Directed bench for vga_fb_display on a shrunken raster (16x16 visible,
// 24 ticks per line, 22 lines per frame) so whole frames fit in a short run.
// Pins for tick t are expected after clock edges 4t+2 .. 4t+5.
module tb_vga_fb_display;

  localparam int HV = 16, HFP = 2, HSY = 4, HBP = 2, HT = 24;
  localparam int VV = 16, VFP = 2, VSY = 2, VBP = 2, VT = 22;
  localparam int FRAME_CLK = 4 * HT * VT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] wr_x = '0;
  logic [7:0] wr_y = '0;
  logic [2:0] wr_color = '0;
  logic       wr_en = 1'b0;
  logic       vga_hs, vga_vs, frame_start;
  logic [3:0] vga_r, vga_g, vga_b;

  int total = 0;
  int bad = 0;
  int cyc;
  int fs_cnt = 0, fs_c0 = -1, fs_c1 = -1;
  int hs_low0 = 0, vs_low0 = 0;
  bit first_run = 1'b1;

  vga_fb_display #(
    .CLK_DIV(4), .FB_W(320), .FB_H(240),
    .H_VIS(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .clk(clk), .reset(reset), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
    .wr_en(wr_en), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_r(vga_r),
    .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_start) begin
      fs_cnt++;
      if (fs_cnt == 1) fs_c0 = cyc;
      else if (fs_cnt == 2) fs_c1 = cyc;
    end
    if (first_run && !reset && cyc < FRAME_CLK) begin
      if (!vga_hs) hs_low0++;
      if (!vga_vs) vs_low0++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: sim time expired, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          h;
    int          v;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } vec_t;

  vec_t tbl[24];

  function automatic int pix_edge(int frame, int h, int v);
    return 4 * ((frame * VT + v) * HT + h) + 3;
  endfunction

  function automatic logic [11:0] exp_rgb(int h, int v, logic [11:0] base);
`ifdef VGA_FB_BORDER_EN
    if (h < HV && v < VV && (h == 0 || h == HV - 1 || v == 0 || v == VV - 1))
      return 12'hFFF;
`endif
    return base;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_edge(int n);
    int guard = 0;
    while (cyc < n) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 50000) begin
        $display("FAIL wait_edge: cycle %0d never reached", n);
        $fatal(1, "wait bound");
      end
    end
  endtask

  task automatic wr(int x, int y, logic [2:0] c);
    @(negedge clk);
    wr_x = 9'(x);
    wr_y = 8'(y);
    wr_color = c;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    int guard;
    logic [13:0] act;

    tbl[0]  = '{0, 0, 12'hF00, 1'b1, 1'b1};
    tbl[1]  = '{1, 0, 12'hF00, 1'b1, 1'b1};
    tbl[2]  = '{2, 0, 12'h000, 1'b1, 1'b1};
    tbl[3]  = '{16, 0, 12'h000, 1'b1, 1'b1};
    tbl[4]  = '{17, 0, 12'h000, 1'b1, 1'b1};
    tbl[5]  = '{18, 0, 12'h000, 1'b0, 1'b1};
    tbl[6]  = '{21, 0, 12'h000, 1'b0, 1'b1};
    tbl[7]  = '{22, 0, 12'h000, 1'b1, 1'b1};
    tbl[8]  = '{0, 1, 12'hF00, 1'b1, 1'b1};
    tbl[9]  = '{1, 1, 12'hF00, 1'b1, 1'b1};
    tbl[10] = '{6, 4, 12'h0F0, 1'b1, 1'b1};
    tbl[11] = '{10, 4, 12'h000, 1'b1, 1'b1};
    tbl[12] = '{10, 8, 12'hFF0, 1'b1, 1'b1};
    tbl[13] = '{0, 12, 12'h000, 1'b1, 1'b1};
    tbl[14] = '{4, 12, 12'h0FF, 1'b1, 1'b1};
    tbl[15] = '{14, 14, 12'h00F, 1'b1, 1'b1};
    tbl[16] = '{15, 14, 12'h00F, 1'b1, 1'b1};
    tbl[17] = '{14, 15, 12'h00F, 1'b1, 1'b1};
    tbl[18] = '{15, 15, 12'h00F, 1'b1, 1'b1};
    tbl[19] = '{0, 16, 12'h000, 1'b1, 1'b1};
    tbl[20] = '{0, 18, 12'h000, 1'b1, 1'b0};
    tbl[21] = '{23, 19, 12'h000, 1'b1, 1'b0};
    tbl[22] = '{0, 20, 12'h000, 1'b1, 1'b1};
    tbl[23] = '{23, 21, 12'h000, 1'b1, 1'b1};

    // Reset held: outputs at reset values while the buffer is loaded.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hs", 32'(vga_hs), 32'd1);
    chk("rst_vs", 32'(vga_vs), 32'd1);
    chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);

    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        wr(x, y, 3'b000);
    wr(0, 0, 3'b100);
    wr(7, 7, 3'b001);
    wr(3, 2, 3'b010);
    wr(5, 4, 3'b110);
    wr(2, 6, 3'b011);
    wr(319, 239, 3'b001);
    wr(320, 5, 3'b111);
    wr(325, 1, 3'b111);
    wr(0, 240, 3'b111);

    @(negedge clk);
    reset = 1'b0;

    // Frame 0 scan against the vector table.
    for (int i = 0; i < 24; i++) begin
      wait_edge(pix_edge(0, tbl[i].h, tbl[i].v));
      act = {vga_r, vga_g, vga_b, vga_hs, vga_vs};
      chk($sformatf("vec%0d(%0d,%0d)", i, tbl[i].h, tbl[i].v), 32'(act),
          32'({exp_rgb(tbl[i].h, tbl[i].v, tbl[i].rgb), tbl[i].hs, tbl[i].vs}));
    end

    // Read-first: write buf(3,5) on the last read of screen (7,11) in frame 1.
    wait_edge(pix_edge(1, 6, 10));
    chk("rf_before", 32'({vga_r, vga_g, vga_b}), 32'h000);
    wait_edge(4 * (HT * VT + 11 * HT + 7) + 3);
    wr_x = 9'd3;
    wr_y = 8'd5;
    wr_color = 3'b101;
    wr_en = 1'b1;
    wait_edge(4 * (HT * VT + 11 * HT + 7) + 4);
    wr_en = 1'b0;
    wait_edge(4 * (HT * VT + 11 * HT + 7) + 5);
    chk("rf_same_clk_old", 32'({vga_r, vga_g, vga_b}), 32'h000);
    wait_edge(pix_edge(2, 6, 10));
    chk("rf_next_frame_new", 32'({vga_r, vga_g, vga_b}), 32'hF0F);

    // Asynchronous reset in the middle of an hsync pulse.
    wait_edge(pix_edge(2, 19, 12));
    chk("pre_rst_hs_low", 32'(vga_hs), 32'd0);
    first_run = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("async_hs", 32'(vga_hs), 32'd1);
    chk("async_vs", 32'(vga_vs), 32'd1);
    chk("async_rgb_fs", 32'({vga_r, vga_g, vga_b, frame_start}), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    guard = 0;
    while (vga_hs && guard < 400) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("hs_fall_cyc", 32'(vga_hs ? -1 : cyc), 32'd74);
    chk("hs_fall_line0_vs", 32'(vga_vs), 32'd1);
    wait_edge(pix_edge(0, 10, 8));
    chk("data_kept_after_rst", 32'({vga_r, vga_g, vga_b}), 32'hFF0);

    chk("fs_count", 32'(fs_cnt), 32'd2);
    chk("fs_first_cyc", 32'(fs_c0), 32'd1536);
    chk("fs_second_cyc", 32'(fs_c1), 32'(1536 + FRAME_CLK));
    chk("hs_low_clk_frame0", 32'(hs_low0), 32'(VT * HSY * 4));
    chk("vs_low_clk_frame0", 32'(vs_low0), 32'(VSY * HT * 4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
